poly_tonegen: RTL and testbench

//   Polyphonic successor to the single-voice tone generator. Consumes received UART bytes as

---
 rtl/poly_tonegen_if.sv | 15 +
 rtl/poly_tonegen.sv | 209 ++++++++++++++++++++
 tb/tb_poly_tonegen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/poly_tonegen_if.sv
// Command/audio bundle between the UART byte source and poly_tonegen.
// The master drives command bytes; the slave (the tone generator) returns audio and status.
interface poly_tonegen_if #(
    parameter int VOICES = 4
);
    logic [7:0]        data;
    logic              data_valid;
    logic              signal;
    logic [VOICES-1:0] active_mask;
    logic              busy;
    logic              overrun;

    modport master (output data, data_valid, input signal, active_mask, busy, overrun);
    modport slave  (input data, data_valid, output signal, active_mask, busy, overrun);
endinterface

// File: rtl/poly_tonegen.sv
// Polyphonic square-wave tone generator with sigma-delta mixing onto a 1-bit output.
// Optional macro TONEGEN_STEAL_EN: a note-on with all voices busy steals a voice round-robin.
//   state   | meaning
//   S_IDLE  | waiting for a command byte
//   S_DIV   | reducing note to (semitone, octave) by repeated subtraction of 12
//   S_ALLOC | allocating / releasing a voice
module poly_tonegen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int VOICES = 4,
    parameter int DIV_W  = 22
) (
    input  logic           clk,
    input  logic           rst_n,
    poly_tonegen_if.slave  bus
);
    localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int SUM_W = $clog2(VOICES + 1);
    localparam int ACC_W = $clog2(2 * VOICES);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_ALLOC} state_t;

    function automatic logic [DIV_W-1:0] rom_val(input int k);
        real r;
        if (k > 11) return '0;
        r = real'(CLK_HZ) / (2.0 * 8.17580 * (2.0 ** (real'(k) / 12.0)));
        return DIV_W'($rtoi(r + 0.5));
    endfunction

    localparam logic [DIV_W-1:0] ROM [16] = '{
        rom_val(0),  rom_val(1),  rom_val(2),  rom_val(3),  rom_val(4),  rom_val(5),
        rom_val(6),  rom_val(7),  rom_val(8),  rom_val(9),  rom_val(10), rom_val(11),
        rom_val(12), rom_val(13), rom_val(14), rom_val(15)};

    state_t             state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [6:0]         rem_q, rem_d;
    logic [3:0]         oct_q, oct_d;
    logic [VOICES-1:0]  mask_q, mask_d;
    logic [VOICES-1:0]  phase_q, phase_d;
    logic [6:0]         note_q [VOICES];
    logic [6:0]         note_d [VOICES];
    logic [DIV_W-1:0]   half_q [VOICES];
    logic [DIV_W-1:0]   half_d [VOICES];
    logic [DIV_W-1:0]   cnt_q  [VOICES];
    logic [DIV_W-1:0]   cnt_d  [VOICES];
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               signal_q, signal_d;
    logic               overrun_q, overrun_d;
`ifdef TONEGEN_STEAL_EN
    logic [PTR_W-1:0]   steal_ptr_q, steal_ptr_d;
`endif

    logic               hit, free;
    logic [PTR_W-1:0]   hit_idx, free_idx;
    logic [DIV_W-1:0]   half_w;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.data_valid && bus.data != 8'h7F) state_d = S_DIV;
            S_DIV:   if (rem_q < 7'd12) state_d = S_ALLOC;
            S_ALLOC: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != S_IDLE);
    end

    always_comb begin
        cmd_d     = cmd_q;
        rem_d     = rem_q;
        oct_d     = oct_q;
        mask_d    = mask_q;
        overrun_d = overrun_q;
        note_d    = note_q;
        half_d    = half_q;
`ifdef TONEGEN_STEAL_EN
        steal_ptr_d = steal_ptr_q;
`endif
        hit = 1'b0; hit_idx = '0; free = 1'b0; free_idx = '0;
        // Descending scan so the lowest matching index wins.
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (mask_q[v] && note_q[v] == cmd_q[6:0]) begin
                hit = 1'b1; hit_idx = PTR_W'(v);
            end
            if (!mask_q[v]) begin
                free = 1'b1; free_idx = PTR_W'(v);
            end
        end
        half_w = ROM[rem_q[3:0]] >> oct_q;

        for (int v = 0; v < VOICES; v++) begin
            if (mask_q[v]) begin
                if (cnt_q[v] == half_q[v] - 1'b1) begin
                    cnt_d[v]   = '0;
                    phase_d[v] = ~phase_q[v];
                end else begin
                    cnt_d[v]   = cnt_q[v] + 1'b1;
                    phase_d[v] = phase_q[v];
                end
            end else begin
                cnt_d[v]   = '0;
                phase_d[v] = 1'b0;
            end
        end

        if (bus.data_valid && state_q != S_IDLE) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: if (bus.data_valid) begin
                if (bus.data == 8'h7F) begin
                    mask_d = '0;
                end else begin
                    cmd_d = bus.data;
                    rem_d = bus.data[6:0];
                    oct_d = '0;
                end
            end
            S_DIV: if (rem_q >= 7'd12) begin
                rem_d = rem_q - 7'd12;
                oct_d = oct_q + 4'd1;
            end
            S_ALLOC: begin
                if (!cmd_q[7]) begin
                    if (hit) mask_d[hit_idx] = 1'b0;
                end else if (hit || free) begin
                    note_d[hit ? hit_idx : free_idx]  = cmd_q[6:0];
                    half_d[hit ? hit_idx : free_idx]  = half_w;
                    cnt_d[hit ? hit_idx : free_idx]   = '0;
                    phase_d[hit ? hit_idx : free_idx] = 1'b0;
                    mask_d[hit ? hit_idx : free_idx]  = 1'b1;
                end else begin
`ifdef TONEGEN_STEAL_EN
                    note_d[steal_ptr_q]  = cmd_q[6:0];
                    half_d[steal_ptr_q]  = half_w;
                    cnt_d[steal_ptr_q]   = '0;
                    phase_d[steal_ptr_q] = 1'b0;
                    steal_ptr_d = (steal_ptr_q == PTR_W'(VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
`else
                    overrun_d = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    // First-order sigma-delta: each cycle emits one pulse per VOICES units accumulated.
    always_comb begin
        sum   = SUM_W'($countones(phase_q & mask_q));
        acc_n = acc_q + ACC_W'(sum);
        if (acc_n >= ACC_W'(VOICES)) begin
            signal_d = 1'b1;
            acc_d    = acc_n - ACC_W'(VOICES);
        end else begin
            signal_d = 1'b0;
            acc_d    = acc_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            rem_q     <= '0;
            oct_q     <= '0;
            mask_q    <= '0;
            phase_q   <= '0;
            acc_q     <= '0;
            signal_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                note_q[v] <= '0;
                half_q[v] <= '0;
                cnt_q[v]  <= '0;
            end
`ifdef TONEGEN_STEAL_EN
            steal_ptr_q <= '0;
`endif
        end else begin
            cmd_q     <= cmd_d;
            rem_q     <= rem_d;
            oct_q     <= oct_d;
            mask_q    <= mask_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            signal_q  <= signal_d;
            overrun_q <= overrun_d;
            note_q    <= note_d;
            half_q    <= half_d;
            cnt_q     <= cnt_d;
`ifdef TONEGEN_STEAL_EN
            steal_ptr_q <= steal_ptr_d;
`endif
        end
    end

    assign bus.signal      = signal_q;
    assign bus.active_mask = mask_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_poly_tonegen.sv
// Directed bench for poly_tonegen: vector table for allocation plus timed corner sequences.
module tb_poly_tonegen;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    poly_tonegen_if #(.VOICES(4)) bus();

    poly_tonegen #(.CLK_HZ(50_000_000), .VOICES(4), .DIV_W(22)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] mask;
        logic       ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.data = 8'h00;
        bus.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.data = b;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        chk({name, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    vec_t vecs [11];
    int   ones;

    initial begin
`ifdef TONEGEN_STEAL_EN
        localparam logic OVF = 1'b0;
        localparam logic [3:0] M_OFF74 = 4'b1110;
`else
        localparam logic OVF = 1'b1;
        localparam logic [3:0] M_OFF74 = 4'b1111;
`endif
        vecs[0]  = '{8'hBC, 4'b0001, 1'b0};
        vecs[1]  = '{8'hC0, 4'b0011, 1'b0};
        vecs[2]  = '{8'hC3, 4'b0111, 1'b0};
        vecs[3]  = '{8'hC7, 4'b1111, 1'b0};
        vecs[4]  = '{8'hCA, 4'b1111, OVF};
        vecs[5]  = '{8'h4A, M_OFF74, OVF};
        vecs[6]  = '{8'hBC, 4'b1111, OVF};
        vecs[7]  = '{8'h40, 4'b1101, OVF};
        vecs[8]  = '{8'h10, 4'b1101, OVF};
        vecs[9]  = '{8'h7F, 4'b0000, OVF};
        vecs[10] = '{8'hC5, 4'b0001, OVF};

        // Reset state
        do_reset();
        chk("rst_mask", 32'(bus.active_mask), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovr", 32'(bus.overrun), 32'd0);
        chk("rst_sig", 32'(bus.signal), 32'd0);

        // Allocation table
        foreach (vecs[i]) begin
            send(vecs[i].data);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_mask", i), 32'(bus.active_mask), 32'(vecs[i].mask));
            chk($sformatf("vec%0d_ovr", i), 32'(bus.overrun), 32'(vecs[i].ov));
        end

        // Note 69 latency: mask appears exactly 7 edges after capture
        do_reset();
        send(8'hC5);
        repeat (6) @(negedge clk);
        chk("lat69_mask6", 32'(bus.active_mask), 32'd0);
        chk("lat69_busy6", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("lat69_mask7", 32'(bus.active_mask), 32'd1);
        chk("lat69_busy7", 32'(bus.busy), 32'd0);

        // Note 127: 12-edge latency, half=1993, first pulse 1997 edges after alloc, density 1/4
        do_reset();
        send(8'hFF);
        repeat (11) @(negedge clk);
        chk("lat127_mask11", 32'(bus.active_mask), 32'd0);
        @(negedge clk);
        chk("lat127_mask12", 32'(bus.active_mask), 32'd1);
        ones = 0;
        for (int j = 13; j <= 2008; j++) begin
            @(negedge clk);
            if (bus.signal) ones++;
        end
        chk("n127_quiet_ones", 32'(ones), 32'd0);
        @(negedge clk);
        chk("n127_first_pulse", 32'(bus.signal), 32'd1);
        ones = 1;
        for (int j = 2010; j <= 2408; j++) begin
            @(negedge clk);
            if (bus.signal) ones++;
        end
        chk("n127_density", 32'(ones), 32'd100);

        // Note-off of note 69 held in voice 1
        do_reset();
        send(8'hBC); wait_idle("off_a");
        send(8'hC5); wait_idle("off_b");
        chk("off_pre_mask", 32'(bus.active_mask), 32'b0011);
        send(8'h45); wait_idle("off_c");
        chk("off_post_mask", 32'(bus.active_mask), 32'b0001);

        // Command 3 cycles after capture is dropped and flags overrun
        do_reset();
        send(8'hFF);
        repeat (2) @(negedge clk);
        bus.data = 8'h80;
        bus.data_valid = 1'b1;
        @(negedge clk);
        bus.data_valid = 1'b0;
        chk("drop_ovr", 32'(bus.overrun), 32'd1);
        chk("drop_busy", 32'(bus.busy), 32'd1);
        wait_idle("drop");
        chk("drop_mask", 32'(bus.active_mask), 32'b0001);

        // Async reset mid-DIV clears everything without a clock edge
        send(8'hFF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_mask", 32'(bus.active_mask), 32'd0);
        chk("arst_ovr", 32'(bus.overrun), 32'd0);
        chk("arst_sig", 32'(bus.signal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hC5);
        wait_idle("arst_after");
        chk("arst_after_mask", 32'(bus.active_mask), 32'b0001);
        chk("arst_after_ovr", 32'(bus.overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
